// File: rtl/zclk_gen.sv
// Z80 CPU clock generator: derives the CPU clock level and its rise/fall
// strobes from the 28 MHz quarter strobes at 3.5, 7 or 14 MHz. Supports
// glitch-free turbo switching, wait-state stretching and a per-frame
// T-state counter.
module zclk_gen #(
  parameter int unsigned TCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c0,
  input  logic              c1,
  input  logic              c2,
  input  logic              c3,
  input  logic [1:0]        turbo_req,
  input  logic              stall,
  input  logic              frame_start,
  output logic              zclk,
  output logic              zpos,
  output logic              zneg,
  output logic [1:0]        turbo_cur,
  output logic [TCNT_W-1:0] tcnt
);

  typedef enum logic [1:0] {
    SPD_3M5     = 2'b00,
    SPD_7M      = 2'b01,
    SPD_14M     = 2'b10,
    SPD_14M_ALT = 2'b11
  } speed_e;

  logic              zclk_q, zclk_d;
  logic              zpos_q, zpos_d;
  logic              zneg_q, zneg_d;
  speed_e            turbo_cur_q, turbo_cur_d;
  logic              div_q, div_d;
  logic              pending_q, pending_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;

  logic   rise_slot, fall_slot;
  logic   do_rise, do_fall;
  logic   req_diff, apply;
  speed_e req_spd;

  // Edge scheduling, turbo switch arbitration and T-state counting
  always_comb begin
    rise_slot = 1'b0;
    fall_slot = 1'b0;
    case (turbo_cur_q)
      SPD_3M5: begin
        rise_slot = c0 & ~div_q;
        fall_slot = c0 & div_q;
      end
      SPD_7M: begin
        rise_slot = c0;
        fall_slot = c2;
      end
      default: begin
        rise_slot = c0 | c2;
        fall_slot = c1 | c3;
      end
    endcase

    do_rise = rise_slot & ~zclk_q & ~stall;
    do_fall = fall_slot & zclk_q;

    zclk_d = zclk_q;
    if (do_rise) begin
      zclk_d = 1'b1;
    end else if (do_fall) begin
      zclk_d = 1'b0;
    end
    zpos_d = do_rise;
    zneg_d = do_fall;

    // The switch gate looks at the post-edge level so that 14 MHz, which is
    // high entering every c3 slot, can still hand over on its c3 fall.
    req_spd     = speed_e'(turbo_req);
    req_diff    = (req_spd != turbo_cur_q);
    apply       = pending_q & req_diff & c3 & ~zclk_d;
    pending_d   = req_diff & ~apply;
    turbo_cur_d = apply ? req_spd : turbo_cur_q;

    div_d = div_q;
    if (apply) begin
      div_d = 1'b0;
    end else if (c0) begin
      div_d = ~div_q;
    end

    tcnt_d = frame_start ? '0 : tcnt_q;
    tcnt_d = tcnt_d + TCNT_W'(do_rise);
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zclk_q      <= 1'b0;
      zpos_q      <= 1'b0;
      zneg_q      <= 1'b0;
      turbo_cur_q <= SPD_3M5;
      div_q       <= 1'b0;
      pending_q   <= 1'b0;
      tcnt_q      <= '0;
    end else begin
      zclk_q      <= zclk_d;
      zpos_q      <= zpos_d;
      zneg_q      <= zneg_d;
      turbo_cur_q <= turbo_cur_d;
      div_q       <= div_d;
      pending_q   <= pending_d;
      tcnt_q      <= tcnt_d;
    end
  end

  assign zclk      = zclk_q;
  assign zpos      = zpos_q;
  assign zneg      = zneg_q;
  assign turbo_cur = turbo_cur_q;
  assign tcnt      = tcnt_q;

endmodule

// File: doc/zclk_gen.md
Name: zclk_gen

Overview:
- Z80 CPU clock generator in the TSConf core.
- Sits directly downstream of the 28 MHz strobe generator and consumes its one-hot quarter strobes c0..c3.
- Produces the CPU clock level plus single-cycle rise/fall strobes at 3.5, 7 or 14 MHz.
- Supports glitch-free turbo switching, wait-state stretching and a per-frame T-state counter.

Parameters:
- TCNT_W, 16, width of the T-state counter.

Ports:
- clk  in  1  28 MHz system clock
- rst_n  in  1  asynchronous active-low reset
- c0  in  1  quarter strobe, phase 0; c0..c3 are one-hot and rotate every clk
- c1  in  1  quarter strobe, phase 90
- c2  in  1  quarter strobe, phase 180
- c3  in  1  quarter strobe, phase 270
- turbo_req  in  2  requested speed: 00=3.5 MHz, 01=7 MHz, 10=14 MHz, 11=14 MHz
- stall  in  1  wait request; suppresses the next rising edge while high
- frame_start  in  1  one-clk pulse; clears the T-state counter
- zclk  out  1  CPU clock level (registered)
- zpos  out  1  one-clk strobe, asserted in the cycle zclk becomes 1
- zneg  out  1  one-clk strobe, asserted in the cycle zclk becomes 0
- turbo_cur  out  2  speed currently in effect
- tcnt  out  TCNT_W  rising edges since last frame_start

Behaviour:
- Reset (async, rst_n=0): zclk=0, zpos=0, zneg=0, turbo_cur=00, div=0, tcnt=0, pending=0. All state updates on posedge clk.
- Edge scheduling, evaluated every clk from turbo_cur and the strobes sampled that cycle. Outputs are registered, so they show 1 clk after the qualifying strobe.
  - 14 MHz (1x): rise slot = c0|c2; fall slot = c1|c3.
  - 7 MHz (01): rise slot = c0; fall slot = c2.
  - 3.5 MHz (00): internal div toggles on every c0. Rise slot = c0&div==0; fall slot = c0&div==1. Period 8 clk, 50% duty.
- Rise: in a rise slot with zclk==0 and stall==0 -> zclk<=1, zpos<=1. With stall==1 the rise is skipped and zclk stays 0 until a later rise slot with stall==0. stall is only sampled in rise slots.
- Fall: in a fall slot with zclk==1 -> zclk<=0, zneg<=1. Falls are never suppressed. With zclk already 0, no zneg.
- zpos/zneg are never both 1. Each lasts exactly 1 clk.
- Turbo switch:
  - turbo_req != turbo_cur sets pending.
  - Applied only on a cycle with c3==1 and zclk==0 (and zclk not rising that cycle): turbo_cur<=turbo_req, div<=0, pending cleared.
  - The first edge at the new speed is a rise at the next c0.
  - If turbo_req changes again before application, the latest value is used. If it returns to turbo_cur, pending clears with no switch.
- Result: no high or low phase is ever shorter than the shorter phase of the faster of the two speeds (1 clk at 14 MHz).
- tcnt: +1 on each zpos, wraps at 2^TCNT_W. frame_start clears it to 0. frame_start and zpos in the same cycle -> tcnt=1.
- Strobes: no strobe asserted -> no edges, state held. More than one strobe asserted is illegal input; the behaviour is don't-care, but the design must not lock up.
- rst_n asserted mid-high-phase: zclk drops to 0 immediately with no zneg. After release, the first rise occurs at the first qualifying c0.

Test Plan:
- Reset, turbo_req=01, stall=0, run 64 clk -> zclk period 4 clk, high 2/low 2. zpos 1 clk after each c0, zneg 1 clk after each c2. tcnt=16 ±1.
- turbo_req=00 -> zclk period 8 clk, 4 high/4 low. After 80 clk, tcnt=10 ±1. turbo_cur=00.
- turbo_req=10 -> zclk toggles every clk. zpos at c0/c2+1, zneg at c1/c3+1. 16 clk give 8 zpos.
- From 7 MHz, change turbo_req to 10 while zclk=1 -> turbo_cur updates only at the next c3 with zclk low. No high or low phase shorter than 1 clk. The first new rise follows c0.
- 7 MHz, hold stall=1 across 3 consecutive c0 slots -> zclk stays low 12+ clk with no zpos. Release before the next c0 -> rise there. tcnt counts only real rises.
- Pulse frame_start on the same cycle as a zpos -> tcnt=1. Set tcnt to 16'hFFFF, then one zpos -> tcnt=0. Assert rst_n low mid-high -> zclk=0 immediately, zneg=0.
